if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the npc/instr pair written into the IF/ID pipeline latch. It holds the PC and runs a req/ack handshake to instruction memory. A one-entry buffer absorbs words that return during a decode stall, and a branch redirect flushes in-flight fetches. It sits between instruction memory and the IF/ID latch; its outputs connect directly to the latch npc/instr inputs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 1, PC increment per fetched word (word-addressed imem)
NOP, 32'h0000_0000, instruction value driven on bubbles and flush

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
stall  input  1  decode cannot accept a new instruction; outputs must hold
br_taken  input  1  redirect request from a later stage; 1-cycle pulse
br_target  input  32  redirect PC, valid while br_taken=1
imem_addr  output  32  fetch address; equals current pc
imem_req  output  1  fetch request; held until ack
imem_rdata  input  32  instruction word, valid while imem_ack=1
imem_ack  input  1  memory response strobe; ignored when imem_req=0
npc_out  output  32  PC+PC_STEP of the presented instruction (to latch npc)
instr_out  output  32  presented instruction (to latch instr)
valid_out  output  1  1 = npc_out/instr_out carry a real instruction

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, state=S_START, imem_req=0, valid_out=0, npc_out=0, instr_out=NOP, buffer empty. All registers update on the rising edge of clk only.
- imem_addr=pc (combinational). imem_req=1 only in S_REQ.
- Handshake: a transfer occurs on a posedge where imem_req=1 and imem_ack=1. imem_addr stays stable until that transfer. Memory latency is unbounded and ack may arrive in the same cycle as req.
- States:
  - S_START: lasts 1 cycle after reset release, then moves to S_REQ.
  - S_REQ, transfer, stall=0: npc_out<=pc+PC_STEP, instr_out<=imem_rdata, valid_out<=1, pc<=pc+PC_STEP. Stays in S_REQ, so back-to-back fetches run at 1 instruction per cycle with a 0-wait memory.
  - S_REQ, transfer, stall=1: buf_instr<=imem_rdata, buf_npc<=pc+PC_STEP, pc<=pc+PC_STEP. Outputs hold. Moves to S_BUF.
  - S_REQ, no transfer, stall=0: bubble. valid_out<=0, instr_out<=NOP, npc_out holds.
  - S_REQ, no transfer, stall=1: outputs hold.
  - S_BUF: imem_req=0. While stall=1, outputs and buffer hold. On the first cycle with stall=0: npc_out<=buf_npc, instr_out<=buf_instr, valid_out<=1, then move to S_REQ.
  - S_FLUSH: imem_req=0 for exactly 1 cycle, then S_REQ. Any ack seen in this state is ignored.
- Redirect: br_taken=1 at a posedge, in any state other than S_START, has top priority over stall and over a simultaneous transfer.
  - pc<=br_target, valid_out<=0, instr_out<=NOP, buffer discarded.
  - A simultaneous imem_rdata is dropped.
  - Next state is S_FLUSH. The first fetch to br_target is issued 2 cycles after the br_taken edge.
- br_taken during S_START: pc<=br_target, then normal flow continues.
- PC arithmetic is modulo 2^32. pc=32'hFFFF_FFFF with PC_STEP=1 wraps to 0, and npc_out=0.
- rst asserted mid-transfer: everything returns to the reset values immediately. Outstanding memory responses after reset release are not transferred until imem_req is reasserted.
- Invariant: valid_out=0 implies instr_out=NOP.

Test Plan:
- Reset, 0-wait memory returning rdata=addr+100, stall=0, 4 cycles after release -> pairs (npc,instr) = (1,100), (2,101), (3,102), valid_out=1 each cycle. The first valid pair appears 2 cycles after rst drops.
- Memory with 2-cycle ack latency -> imem_addr stable over 3 cycles while imem_req=1, with valid_out=0 and instr_out=0 between words. Each word is presented exactly once.
- stall=1 asserted while ack returns word for addr 5 -> outputs frozen, imem_req=0 in S_BUF. Drop stall after 3 cycles -> next cycle npc_out=6, instr_out=105, valid_out=1, then fetch of addr 6.
- br_taken=1 with br_target=32'h40, in the same cycle as an ack and with stall=1 -> valid_out=0, instr_out=0, buffered/acked word discarded. imem_req=0 for 1 cycle, then imem_addr=32'h40. First valid output: npc_out=32'h41.
- RESET_PC=32'hFFFF_FFFF override -> first presented npc_out=0, and the next fetch address is 0.
- rst pulsed asynchronously (between clock edges) during S_BUF -> outputs immediately valid_out=0, npc_out=0, imem_req=0. Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
`timescale 1ns/1ps
// if_fetch_unit
// Instruction-fetch stage that feeds the IF/ID pipeline latch. It holds the
// PC, runs a req/ack handshake with instruction memory, parks one returned
// word in a single-entry buffer while decode is stalled, and flushes
// in-flight fetches on a branch redirect.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   stall                 decode cannot accept; presented outputs hold
//   br_taken, br_target   one-cycle redirect request and its target PC
//   imem_addr, imem_req   fetch address (= pc) and request (held until ack)
//   imem_rdata, imem_ack  returned instruction word and response strobe
//   npc_out, instr_out    PC+PC_STEP and instruction presented to IF/ID
//   valid_out             npc_out/instr_out carry a real instruction
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] npc_out,
  output logic [31:0] instr_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_REQ   = 2'd1,
    S_BUF   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t      state_p0;
  state_t      state_nxt;
  logic [31:0] pc_p0;
  logic [31:0] buf_npc_p0;
  logic [31:0] buf_instr_p0;
  logic [31:0] npc_p1;
  logic [31:0] instr_p1;
  logic        vld_p1;

  logic        redirect;
  logic        xfer;
  logic        present_mem;
  logic        present_buf;
  logic        bubble;
  logic        buf_wr;

  // PC arithmetic wraps modulo 2^32.
  function automatic logic [31:0] pc_add(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  // A redirect in S_START only retargets the PC; everywhere else it also
  // kills the presented word, the buffer and any simultaneous transfer.
  assign redirect  = br_taken && (state_p0 != S_START);
  assign xfer      = (state_p0 == S_REQ) && imem_ack;
  assign imem_addr = pc_p0;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= S_START;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      S_START: state_nxt = S_REQ;
      S_REQ: begin
        if (redirect)          state_nxt = S_FLUSH;
        else if (xfer && stall) state_nxt = S_BUF;
      end
      S_BUF: begin
        if (redirect)    state_nxt = S_FLUSH;
        else if (!stall) state_nxt = S_REQ;
      end
      S_FLUSH: begin
        if (redirect) state_nxt = S_FLUSH;
        else          state_nxt = S_REQ;
      end
      default: state_nxt = S_START;
    endcase
  end

  // Output / datapath-control decode
  always_comb begin
    imem_req    = (state_p0 == S_REQ);
    present_mem = !redirect && xfer && !stall;
    present_buf = !redirect && (state_p0 == S_BUF) && !stall;
    bubble      = !redirect && (state_p0 == S_REQ) && !imem_ack && !stall;
    buf_wr      = !redirect && xfer && stall;
  end

  // ---- stage p0: PC ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0 <= RESET_PC;
    end else if (br_taken) begin
      pc_p0 <= br_target;
    end else if (xfer) begin
      pc_p0 <= pc_add(pc_p0);
    end
  end

  // Buffer contents are meaningful only in S_BUF, so they need no reset.
  always_ff @(posedge clk) begin
    if (buf_wr) begin
      buf_npc_p0   <= pc_add(pc_p0);
      buf_instr_p0 <= imem_rdata;
    end
  end

  // ---- stage p1: IF/ID presentation ----
  // Every path that clears vld_p1 also forces NOP, keeping the
  // "invalid implies NOP" invariant by construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      npc_p1   <= 32'h0;
      instr_p1 <= NOP;
      vld_p1   <= 1'b0;
    end else if (redirect) begin
      instr_p1 <= NOP;
      vld_p1   <= 1'b0;
    end else if (present_mem) begin
      npc_p1   <= pc_add(pc_p0);
      instr_p1 <= imem_rdata;
      vld_p1   <= 1'b1;
    end else if (present_buf) begin
      npc_p1   <= buf_npc_p0;
      instr_p1 <= buf_instr_p0;
      vld_p1   <= 1'b1;
    end else if (bubble) begin
      instr_p1 <= NOP;
      vld_p1   <= 1'b0;
    end
  end

  assign npc_out   = npc_p1;
  assign instr_out = instr_p1;
  assign valid_out = vld_p1;

endmodule

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
module tb_if_fetch_unit;

  localparam logic [31:0] NOPV = 32'h0000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] npc_out;
  logic [31:0] instr_out;
  logic        valid_out;

  // Second instance with a wrapping reset PC, zero-wait memory, no stalls.
  logic        stall2;
  logic        br2;
  logic [31:0] br_target2;
  logic [31:0] imem_addr2;
  logic        imem_req2;
  logic [31:0] imem_rdata2;
  logic        imem_ack2;
  logic [31:0] npc2;
  logic [31:0] instr2;
  logic        valid2;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .npc_out(npc_out),
    .instr_out(instr_out), .valid_out(valid_out)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall2), .br_taken(br2),
    .br_target(br_target2), .imem_addr(imem_addr2), .imem_req(imem_req2),
    .imem_rdata(imem_rdata2), .imem_ack(imem_ack2), .npc_out(npc2),
    .instr_out(instr2), .valid_out(valid2)
  );

  typedef struct {
    logic [31:0] npc;
    logic [31:0] instr;
  } word_t;

  // Reference model: what the latch should show, where fetching stands,
  // and the words waiting for decode to accept them.
  logic [31:0] m_pc, m_npc, m_instr;
  logic        m_vld, m_start, m_flush;
  word_t       m_held[$];

  int checks   = 0;
  int failures = 0;
  int mem_wait = 0;
  int lat_min  = 0;
  int lat_max  = 0;
  bit spur_en  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_npc   = 32'h0;
    m_instr = NOPV;
    m_vld   = 1'b0;
    m_start = 1'b1;
    m_flush = 1'b0;
    m_held.delete();
    mem_wait = 0;
  endtask

  // One clock: drive memory, check request side, step the model, check outputs.
  task automatic cycle();
    logic        exp_req, rq, s, b, a;
    logic [31:0] t, d;
    word_t       w;
    exp_req = !m_start && !m_flush && (m_held.size() == 0);
    chk("req", imem_req, exp_req);
    chk("addr", imem_addr, m_pc);
    rq = imem_req;
    if (rq) begin
      imem_ack   = (mem_wait == 0);
      imem_rdata = imem_addr + 32'd100;
    end else begin
      imem_ack   = spur_en ? ($urandom_range(0, 1) == 1) : 1'b0;
      imem_rdata = $urandom;
    end
    imem_rdata2 = imem_addr2 + 32'd100;
    s = stall; b = br_taken; t = br_target; d = imem_rdata;
    a = imem_ack && exp_req;
    @(posedge clk);
    if (rq && imem_ack) mem_wait = $urandom_range(lat_min, lat_max);
    else if (rq && mem_wait > 0) mem_wait--;
    if (m_start) begin
      if (b) m_pc = t;
      m_start = 1'b0;
    end else if (b) begin
      m_pc = t; m_vld = 1'b0; m_instr = NOPV; m_held.delete(); m_flush = 1'b1;
    end else if (m_flush) begin
      m_flush = 1'b0;
    end else if (m_held.size() > 0) begin
      if (!s) begin
        w = m_held.pop_front();
        m_npc = w.npc; m_instr = w.instr; m_vld = 1'b1;
      end
    end else if (a) begin
      w.npc = m_pc + 32'd1;
      w.instr = d;
      m_pc = w.npc;
      if (s) m_held.push_back(w);
      else begin
        m_npc = w.npc; m_instr = w.instr; m_vld = 1'b1;
      end
    end else if (!s) begin
      m_vld = 1'b0; m_instr = NOPV;
    end
    #1;
    chk("npc", npc_out, m_npc);
    chk("instr", instr_out, m_instr);
    chk("valid", valid_out, m_vld);
    if (!valid_out) chk("inv_nop", instr_out, NOPV);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    stall2 = 1'b0; br2 = 1'b0; br_target2 = 32'h0; imem_ack2 = 1'b1; imem_rdata2 = 32'h0;
    model_reset();

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_npc", npc_out, 0);
    chk("rst_instr", instr_out, NOPV);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_addr_wrap", imem_addr2, 32'hFFFF_FFFF);
    rst = 1'b0;

    // Zero-wait back-to-back fetch; wrap instance presents npc=0
    cycle();
    chk("t1_start_valid", valid_out, 0);
    chk("wrap_req", imem_req2, 1);
    chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFF);
    cycle();
    chk("t1_npc1", npc_out, 1); chk("t1_instr1", instr_out, 100); chk("t1_v1", valid_out, 1);
    chk("wrap_npc", npc2, 32'h0); chk("wrap_instr", instr2, 32'd99);
    chk("wrap_valid", valid2, 1); chk("wrap_next_addr", imem_addr2, 32'h0);
    cycle();
    chk("t1_npc2", npc_out, 2); chk("t1_instr2", instr_out, 101); chk("t1_v2", valid_out, 1);
    cycle();
    chk("t1_npc3", npc_out, 3); chk("t1_instr3", instr_out, 102); chk("t1_v3", valid_out, 1);

    // Two-cycle ack latency: address held, bubbles between words
    lat_min = 2; lat_max = 2; mem_wait = 2;
    for (int wd = 0; wd < 2; wd++) begin
      for (int i = 0; i < 3; i++) begin
        chk("t2_addr", imem_addr, 32'(3 + wd));
        chk("t2_req", imem_req, 1);
        cycle();
        if (i < 2) begin
          chk("t2_bub_valid", valid_out, 0);
          chk("t2_bub_instr", instr_out, NOPV);
        end else begin
          chk("t2_npc", npc_out, 32'(4 + wd));
          chk("t2_instr", instr_out, 32'(103 + wd));
          chk("t2_valid", valid_out, 1);
        end
      end
    end

    // Stall while word for addr 5 returns: buffered, then presented
    lat_min = 0; lat_max = 0; mem_wait = 0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_hold_npc", npc_out, 5);
      chk("t3_hold_instr", instr_out, 104);
      chk("t3_hold_valid", valid_out, 1);
      chk("t3_buf_req", imem_req, 0);
    end
    stall = 1'b0;
    cycle();
    chk("t3_npc", npc_out, 6); chk("t3_instr", instr_out, 105); chk("t3_valid", valid_out, 1);
    chk("t3_req", imem_req, 1); chk("t3_addr", imem_addr, 6);

    // Redirect with simultaneous ack and stall
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h40;
    cycle();
    chk("t4_valid", valid_out, 0); chk("t4_instr", instr_out, NOPV); chk("t4_req", imem_req, 0);
    stall = 1'b0; br_taken = 1'b0;
    cycle();
    chk("t4_req2", imem_req, 1); chk("t4_addr", imem_addr, 32'h40); chk("t4_valid2", valid_out, 0);
    cycle();
    chk("t4_npc", npc_out, 32'h41); chk("t4_instr", instr_out, 32'h40 + 32'd100);
    chk("t4_valid3", valid_out, 1);

    // Asynchronous reset while holding a buffered word
    stall = 1'b1;
    cycle();
    chk("t6_buf_req", imem_req, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", valid_out, 0); chk("t6_npc", npc_out, 0);
    chk("t6_instr", instr_out, NOPV); chk("t6_req", imem_req, 0); chk("t6_addr", imem_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0; stall = 1'b0;
    model_reset();
    cycle();
    cycle();
    chk("t6_npc1", npc_out, 1); chk("t6_instr1", instr_out, 100); chk("t6_valid1", valid_out, 1);

    // Randomized traffic against the model
    spur_en = 1'b1; lat_min = 0; lat_max = 3;
    for (int n = 0; n < 600; n++) begin
      stall    = ($urandom_range(0, 9) < 3);
      br_taken = ($urandom_range(0, 19) == 0);
      br_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      cycle();
    end
    br_taken = 1'b0; stall = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
